// File: rtl/ex_mem_pkg.sv
// Shared constants and the per-cycle update decode for the EX/MEM pipeline register.
// Carries the OpenMIPS define names so ported code keeps reading the same.
package ex_mem_pkg;

  localparam logic        RstEnable    = 1'b0;
  localparam logic        RstDisable   = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  localparam int unsigned STALL_EX_BIT  = 3;
  localparam int unsigned STALL_MEM_BIT = 4;

  typedef enum logic [1:0] {
    ACT_CLEAR,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } ex_mem_act_e;

  // Flush beats stall; an EX stall without a MEM stall leaves a bubble behind.
  function automatic ex_mem_act_e decode_act(input logic flush,
                                             input logic stall_ex,
                                             input logic stall_mem);
    ex_mem_act_e act;
    if (flush)
      act = ACT_CLEAR;
    else if (stall_ex == Stop && stall_mem == NoStop)
      act = ACT_BUBBLE;
    else if (stall_ex == NoStop)
      act = ACT_ADVANCE;
    else
      act = ACT_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX -> MEM pipeline register with bubble/hold/flush control and the
// multiply-accumulate partial-product feedback register.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [AW-1:0]       ex_wd,
  input  logic                ex_wreg,
  input  logic [DW-1:0]       ex_wdata,
  input  logic [DW-1:0]       ex_hi,
  input  logic [DW-1:0]       ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DW-1:0]     hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [AW-1:0]       mem_wd,
  output logic                mem_wreg,
  output logic [DW-1:0]       mem_wdata,
  output logic [DW-1:0]       mem_hi,
  output logic [DW-1:0]       mem_lo,
  output logic                mem_whilo,
  output logic [2*DW-1:0]     hilo_o,
  output logic [1:0]          cnt_o
);

  localparam logic [STALL_W-1:0] STALL_EX_MASK  = STALL_W'(1) << STALL_EX_BIT;
  localparam logic [STALL_W-1:0] STALL_MEM_MASK = STALL_W'(1) << STALL_MEM_BIT;

  logic        stall_ex;
  logic        stall_mem;
  ex_mem_act_e act;

  logic [AW-1:0]   wd_q,    wd_d;
  logic            wreg_q,  wreg_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   hi_q,    hi_d;
  logic [DW-1:0]   lo_q,    lo_d;
  logic            whilo_q, whilo_d;
  logic [2*DW-1:0] hilo_q,  hilo_d;
  logic [1:0]      cnt_q,   cnt_d;

  assign stall_ex  = |(stall & STALL_EX_MASK);
  assign stall_mem = |(stall & STALL_MEM_MASK);

  always_comb begin
    act = decode_act(flush, stall_ex, stall_mem);
  end

  // The accumulator follows EX whenever EX is held and is cleared once EX moves on.
  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    hilo_d  = hilo_i;
    cnt_d   = cnt_i;
    unique case (act)
      ACT_CLEAR: begin
        wd_d    = '0;
        wreg_d  = WriteDisable;
        wdata_d = '0;
        hi_d    = '0;
        lo_d    = '0;
        whilo_d = WriteDisable;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      ACT_BUBBLE: begin
        wd_d    = '0;
        wreg_d  = WriteDisable;
        wdata_d = '0;
        hi_d    = '0;
        lo_d    = '0;
        whilo_d = WriteDisable;
      end
      ACT_ADVANCE: begin
        wd_d    = ex_wd;
        wreg_d  = ex_wreg;
        wdata_d = ex_wdata;
        hi_d    = ex_hi;
        lo_d    = ex_lo;
        whilo_d = ex_whilo;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      ACT_HOLD: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wd_q    <= '0;
      wreg_q  <= WriteDisable;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= WriteDisable;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: a per-edge reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_ex_mem;

  localparam int unsigned SW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic            clk;
  logic            rst;
  logic [SW-1:0]   stall;
  logic            flush;
  logic [AW-1:0]   ex_wd;
  logic            ex_wreg;
  logic [DW-1:0]   ex_wdata;
  logic [DW-1:0]   ex_hi;
  logic [DW-1:0]   ex_lo;
  logic            ex_whilo;
  logic [2*DW-1:0] hilo_i;
  logic [1:0]      cnt_i;
  logic [AW-1:0]   mem_wd;
  logic            mem_wreg;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_hi;
  logic [DW-1:0]   mem_lo;
  logic            mem_whilo;
  logic [2*DW-1:0] hilo_o;
  logic [1:0]      cnt_o;

  int checks   = 0;
  int failures = 0;

  ex_mem #(.STALL_W(SW), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the MEM side must hold after each edge.
  logic [AW-1:0]   e_wd;
  logic            e_wreg;
  logic [DW-1:0]   e_wdata, e_hi, e_lo;
  logic            e_whilo;
  logic [2*DW-1:0] e_hilo;
  logic [1:0]      e_cnt;
  bit              model_ok = 0;

  always @(posedge clk) begin
    bit ex_held, mem_held;
    ex_held  = stall[3];
    mem_held = stall[4];
    if (!rst || flush) begin
      {e_wd, e_wreg, e_wdata, e_hi, e_lo, e_whilo} = '0;
      e_hilo = '0;
      e_cnt  = '0;
      if (!rst) model_ok = 1;
    end else if (!ex_held) begin
      if (mem_held)
        $display("NOTE illegal stall pattern %b (MEM held, EX free) at %0t", stall, $time);
      e_wd = ex_wd; e_wreg = ex_wreg; e_wdata = ex_wdata;
      e_hi = ex_hi; e_lo = ex_lo; e_whilo = ex_whilo;
      e_hilo = '0;
      e_cnt  = '0;
    end else begin
      if (!mem_held)
        {e_wd, e_wreg, e_wdata, e_hi, e_lo, e_whilo} = '0;
      e_hilo = hilo_i;
      e_cnt  = cnt_i;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      cmp("mem_wd",    64'(mem_wd),    64'(e_wd));
      cmp("mem_wreg",  64'(mem_wreg),  64'(e_wreg));
      cmp("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      cmp("mem_hi",    64'(mem_hi),    64'(e_hi));
      cmp("mem_lo",    64'(mem_lo),    64'(e_lo));
      cmp("mem_whilo", 64'(mem_whilo), 64'(e_whilo));
      cmp("hilo_o",    hilo_o,         e_hilo);
      cmp("cnt_o",     64'(cnt_o),     64'(e_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [SW-1:0] sweep [8] = '{6'b000000, 6'b001111, 6'b011111, 6'b111111,
                               6'b010000, 6'b000111, 6'b001000, 6'b011000};

  initial begin
    rst = 1'b0; flush = 1'b0; stall = '0;
    ex_wd = '0; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
    ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0; hilo_i = '0; cnt_i = '0;

    // Reset holds everything at zero regardless of EX.
    step(); step();
    cmp("lit_rst_wdata", 64'(mem_wdata), 64'h0);
    cmp("lit_rst_wreg",  64'(mem_wreg),  64'h0);
    cmp("lit_rst_hilo",  hilo_o,         64'h0);
    cmp("lit_rst_cnt",   64'(cnt_o),     64'h0);

    rst = 1'b1;
    step();
    cmp("lit_post_rst_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    cmp("lit_post_rst_wreg",  64'(mem_wreg),  64'h1);

    // Normal advance.
    ex_wd = 5'd3; ex_wdata = 32'h1234; ex_whilo = 1'b1; ex_hi = 32'hA; ex_lo = 32'hB;
    step();
    cmp("lit_adv_wd",    64'(mem_wd),    64'd3);
    cmp("lit_adv_wdata", 64'(mem_wdata), 64'h1234);
    cmp("lit_adv_whilo", 64'(mem_whilo), 64'h1);
    cmp("lit_adv_hi",    64'(mem_hi),    64'hA);
    cmp("lit_adv_lo",    64'(mem_lo),    64'hB);
    cmp("lit_adv_cnt",   64'(cnt_o),     64'h0);

    // Bubble with a pending MADD, then release.
    stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
    step();
    cmp("lit_bub_wd",    64'(mem_wd),    64'h0);
    cmp("lit_bub_wdata", 64'(mem_wdata), 64'h0);
    cmp("lit_bub_whilo", 64'(mem_whilo), 64'h0);
    cmp("lit_bub_hilo",  hilo_o,         64'h1_0000_0002);
    cmp("lit_bub_cnt",   64'(cnt_o),     64'h1);
    stall = '0; ex_wdata = 32'h777;
    step();
    cmp("lit_rel_wdata", 64'(mem_wdata), 64'h777);
    cmp("lit_rel_wd",    64'(mem_wd),    64'd3);
    cmp("lit_rel_hilo",  hilo_o,         64'h0);
    cmp("lit_rel_cnt",   64'(cnt_o),     64'h0);

    // Hold keeps MEM, accumulator tracks EX.
    ex_wdata = 32'h55;
    step();
    stall = 6'b011111; ex_wdata = 32'h99; hilo_i = 64'hAAAA_0000_0000_BBBB; cnt_i = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("lit_hold_wdata", 64'(mem_wdata), 64'h55);
    end
    cmp("lit_hold_hilo", hilo_o,     64'hAAAA_0000_0000_BBBB);
    cmp("lit_hold_cnt",  64'(cnt_o), 64'h2);

    // Flush mid-MADD discards the partial product.
    stall = 6'b001111; hilo_i = 64'hCAFE_0000_0000_0001; cnt_i = 2'd1;
    step();
    cmp("lit_madd_cnt",  64'(cnt_o), 64'h1);
    cmp("lit_madd_hilo", hilo_o,     64'hCAFE_0000_0000_0001);
    flush = 1'b1;
    step();
    cmp("lit_flush_cnt",   64'(cnt_o),     64'h0);
    cmp("lit_flush_hilo",  hilo_o,         64'h0);
    cmp("lit_flush_wdata", 64'(mem_wdata), 64'h0);

    // Reset together with flush and stall, then recovery.
    rst = 1'b0; flush = 1'b1; ex_wdata = 32'hABC; ex_wreg = 1'b1;
    step();
    cmp("lit_rstfl_wdata", 64'(mem_wdata), 64'h0);
    cmp("lit_rstfl_cnt",   64'(cnt_o),     64'h0);
    rst = 1'b1; flush = 1'b0; stall = '0;
    step();
    cmp("lit_resume_wdata", 64'(mem_wdata), 64'hABC);
    cmp("lit_resume_wreg",  64'(mem_wreg),  64'h1);

    // MEM stalled alone still advances.
    stall = 6'b010000; ex_wdata = 32'h5A5A; hilo_i = 64'h1; cnt_i = 2'd3;
    step();
    cmp("lit_illegal_wdata", 64'(mem_wdata), 64'h5A5A);
    cmp("lit_illegal_cnt",   64'(cnt_o),     64'h0);

    // Stall/flush sweep checked by the model only.
    for (int i = 0; i < 24; i++) begin
      stall    = sweep[i % 8];
      flush    = (i % 7 == 5);
      ex_wd    = AW'(i + 1);
      ex_wreg  = i[0];
      ex_whilo = i[1];
      ex_wdata = 32'h1111_0000 + 32'(i);
      ex_hi    = 32'h2000 + 32'(i);
      ex_lo    = 32'h3000 + 32'(i);
      hilo_i   = {32'h4000 + 32'(i), 32'h5000 + 32'(i)};
      cnt_i    = 2'(i);
      step();
    end
    flush = 1'b0; stall = '0;
    step();
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage OpenMIPS core.
- Latches EX results on each clock: destination address, write enable, write data, and the HI/LO write request.
- Inserts bubbles, holds, or flushes under control of the central stall/flush controller.
- Holds the temporary 64-bit accumulator and cycle counter for two-cycle MADD/MADDU/MSUB/MSUBU, and feeds both back to EX.

Parameters:
- STALL_W, 6, width of the stall vector; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- DW, 32, data word width (RegBus).
- AW, 5, register address width (RegAddrBus).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- stall  in  STALL_W  stall request vector from the control unit.
- flush  in  1  exception/pipeline flush.
- ex_wd  in  AW  EX destination register address.
- ex_wreg  in  1  EX register write enable.
- ex_wdata  in  DW  EX result.
- ex_hi  in  DW  EX HI value to write.
- ex_lo  in  DW  EX LO value to write.
- ex_whilo  in  1  EX HI/LO write enable.
- hilo_i  in  2*DW  partial product from EX during multi-cycle multiply-accumulate.
- cnt_i  in  2  EX multi-cycle step counter.
- mem_wd  out  AW  registered destination address.
- mem_wreg  out  1  registered write enable.
- mem_wdata  out  DW  registered result.
- mem_hi  out  DW  registered HI value.
- mem_lo  out  DW  registered LO value.
- mem_whilo  out  1  registered HI/LO write enable.
- hilo_o  out  2*DW  stored partial product, fed back to EX.
- cnt_o  out  2  stored step counter, fed back to EX.

Behaviour:
- All outputs are registers. Latency is 1 cycle from ex_* to mem_*. There is no combinational path from inputs to outputs.
- Priority at each rising clk edge:
  - (1) rst == 0 → all outputs 0 (mem_*, hilo_o, cnt_o).
  - (2) flush == 1 → same as reset; all outputs 0.
  - (3) stall[3] == 1 && stall[4] == 0 → bubble. mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo become 0. hilo_o <= hilo_i and cnt_o <= cnt_i, so the partial product survives while EX is held.
  - (4) stall[3] == 0 → normal advance. mem_* <= ex_*. hilo_o <= 0 and cnt_o <= 0, which clears the accumulator once EX completes.
  - (5) otherwise (stall[3] == 1 && stall[4] == 1) → hold. All mem_* keep their value; hilo_o <= hilo_i; cnt_o <= cnt_i.
- State summary (implicit, per cycle): ADVANCE, BUBBLE, HOLD, CLEAR (reset/flush).
- Multi-cycle sequencing, driven by EX:
  - Cycle A: EX raises its stall and presents hilo_i = product, cnt_i = 1.
  - The next cycle sees hilo_o = product and cnt_o = 1.
  - Cycle B: EX releases the stall; rule (4) commits the result and clears hilo_o and cnt_o to 0.
- Boundary cases:
  - Flush during a pending MADD (cnt_o = 1) discards the partial product; cnt_o = 0 afterwards.
  - Reset wins over flush and stall.
  - stall[4] alone (stall[3] == 0) is illegal from the controller. The block still applies rule (4), with no assertion in RTL; the bench flags this case.
  - Widths are exact: no truncation or extension; hilo_o is {hi, lo}.

Decomposition:
- Shared defines header (existing defines.v): RstEnable for active-low (1'b0), ZeroWord, RegBus, RegAddrBus, DoubleRegBus, WriteEnable, WriteDisable, Stop, NoStop.
- No sub-module. A single always block with a priority if-chain is sufficient.

Test Plan:
- Reset: rst = 0 for 2 cycles with ex_wdata = 32'hDEADBEEF, ex_wreg = 1 → all outputs 0. After rst = 1, the next edge gives mem_wdata = 32'hDEADBEEF, mem_wreg = 1.
- Normal advance: ex_wd = 5'd3, ex_wdata = 32'h1234, ex_whilo = 1, ex_hi = 32'hA, ex_lo = 32'hB, stall = 0 → one cycle later mem_wd = 3, mem_wdata = 32'h1234, mem_whilo = 1, mem_hi = A, mem_lo = B, cnt_o = 0.
- Bubble: stall = 6'b001111, hilo_i = 64'h1_0000_0002, cnt_i = 1 → mem_* all 0; hilo_o = 64'h1_0000_0002; cnt_o = 1. Release with stall = 0 → mem_* take ex_*; hilo_o = 0; cnt_o = 0.
- Hold: load mem_wdata = 32'h55, then stall = 6'b011111 for 3 cycles with ex_wdata = 32'h99 → mem_wdata stays 32'h55 throughout.
- Flush mid-MADD: cnt_o = 1 and hilo_o nonzero, then flush = 1 together with stall = 6'b001111 → next cycle all outputs 0.
- Reset vs flush priority: rst = 0 and flush = 1 in the same cycle → all outputs 0. Then rst = 1, flush = 0, stall = 0 → normal capture resumes on the following edge.
